// File: rtl/mod_count_sequencer.sv
// Command-driven programmable modulo counter: runs a latched modulus/direction for a
// number of wrap-arounds (or free-runs), with pause/abort and tc/wrap/done reporting.
`timescale 1ns/1ps

//  state    | meaning
//  ST_IDLE  | waiting for a command; cmd_ready high, count holds
//  ST_RUN   | counting with the latched term/reps/direction; busy high
//  ST_DONE  | single cycle after the final wrap; done pulse visible
module mod_count_sequencer #(
   parameter int WIDTH = 4,
   parameter int REP_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_term,
   input  logic [REP_W-1:0] cmd_reps,
   input  logic             cmd_up,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic [REP_W-1:0] wraps,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_term;
   logic [REP_W-1:0] r_reps;
   logic             r_up;
   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic [REP_W-1:0] r_wraps;
   logic             r_done;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_term_nxt;
   logic [REP_W-1:0] w_reps_nxt;
   logic             w_up_nxt;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_tc_nxt;
   logic [REP_W-1:0] w_wraps_nxt;
   logic             w_done_nxt;

   logic             w_at_end;
   logic [REP_W-1:0] w_wraps_inc;

   // End of span depends on direction: term when counting up, zero when counting down.
   assign w_at_end    = r_up ? (r_count == r_term) : (r_count == '0);
   assign w_wraps_inc = r_wraps + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_term  <= '0;
         r_reps  <= '0;
         r_up    <= 1'b0;
         r_count <= '0;
         r_tc    <= 1'b0;
         r_wraps <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_term  <= w_term_nxt;
         r_reps  <= w_reps_nxt;
         r_up    <= w_up_nxt;
         r_count <= w_count_nxt;
         r_tc    <= w_tc_nxt;
         r_wraps <= w_wraps_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_term_nxt  = r_term;
      w_reps_nxt  = r_reps;
      w_up_nxt    = r_up;
      w_count_nxt = r_count;
      w_tc_nxt    = 1'b0;
      w_wraps_nxt = r_wraps;
      w_done_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_term_nxt  = cmd_term;
               w_reps_nxt  = cmd_reps;
               w_up_nxt    = cmd_up;
               w_count_nxt = cmd_up ? '0 : cmd_term;
               w_wraps_nxt = '0;
               w_state_nxt = ST_RUN;
            end
         end

         ST_RUN: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
               w_count_nxt = '0;
               w_wraps_nxt = '0;
            end else if (!pause) begin
               if (!w_at_end) begin
                  w_count_nxt = r_up ? (r_count + 1'b1) : (r_count - 1'b1);
               end else begin
                  w_count_nxt = r_up ? '0 : r_term;
                  w_tc_nxt    = 1'b1;
                  w_wraps_nxt = w_wraps_inc;
                  // reps of zero never matches, so the counter free-runs.
                  if ((r_reps != '0) && (w_wraps_inc == r_reps)) begin
                     w_state_nxt = ST_DONE;
                     w_done_nxt  = 1'b1;
                  end
               end
            end
         end

         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = (r_state == ST_RUN);
   assign count     = r_count;
   assign tc        = r_tc;
   assign wraps     = r_wraps;
   assign done      = r_done;

endmodule

// File: tb/tb_mod_count_sequencer.sv
// Scoreboard bench for mod_count_sequencer: expected output rows are derived
// arithmetically from edges-since-accept and compared one edge later.
`timescale 1ns/1ps

module tb_mod_count_sequencer;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_term;
   logic [7:0] cmd_reps;
   logic       cmd_up;
   logic       pause;
   logic       abort;
   logic [3:0] count;
   logic       tc;
   logic [7:0] wraps;
   logic       busy;
   logic       done;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;

   exp_t exp_q[$];

   mod_count_sequencer #(.WIDTH(4), .REP_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_term  (cmd_term),
      .cmd_reps  (cmd_reps),
      .cmd_up    (cmd_up),
      .pause     (pause),
      .abort     (abort),
      .count     (count),
      .tc        (tc),
      .wraps     (wraps),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] w_obs;
   assign w_obs = {16'd0, count, tc, wraps, busy, done, cmd_ready};

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_chk++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h (count,tc,wraps,busy,done,ready)", tag, got, expv);
      end
   endtask

   function automatic logic [31:0] row(input int cnt, input bit t_c, input int wr,
                                       input bit b, input bit d, input bit rd);
      logic [3:0] c4;
      logic [7:0] w8;
      c4 = cnt[3:0];
      w8 = wr[7:0];
      return {16'd0, c4, t_c, w8, b, d, rd};
   endfunction

   function automatic int cnt_of(input int t, input bit up, input int k);
      int n;
      n = t + 1;
      return up ? (k % n) : (t - (k % n));
   endfunction

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      exp_q.push_back(e);
   endtask

   // Each pushed row describes the outputs expected just after the next rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk_val(e.tag, w_obs, e.v);
      end
   end

   // k counts unpaused edges since accept; all expectations follow from k, t, r.
   task automatic run_cmd(input string name, input int t, input int r, input bit up,
                          input int p_at, input int p_len, input int ab_at, input int v_at);
      int n;
      int k;
      int cyc;
      bit fin;
      bit dn;
      n   = t + 1;
      k   = 0;
      cyc = 0;
      fin = 1'b0;
      dn  = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_term  = t[3:0];
      cmd_reps  = r[7:0];
      cmd_up    = up;
      push($sformatf("%s_acc", name), row(cnt_of(t, up, 0), 1'b0, 0, 1'b1, 1'b0, 1'b0));
      while (!fin) begin
         @(negedge clk);
         cyc++;
         cmd_valid = 1'b0;
         if (cyc == v_at) begin
            cmd_valid = 1'b1;
            cmd_term  = 4'd9;
            cmd_up    = ~up;
            cmd_reps  = 8'd7;
         end
         if (dn) begin
            pause = 1'b0;
            abort = 1'b0;
            push($sformatf("%s_idle", name), row(cnt_of(t, up, k), 1'b0, r, 1'b0, 1'b0, 1'b1));
            fin = 1'b1;
         end else begin
            pause = (cyc >= p_at) && (cyc < p_at + p_len);
            abort = (cyc == ab_at);
            if (abort) begin
               push($sformatf("%s_abort", name), row(0, 1'b0, 0, 1'b0, 1'b0, 1'b1));
               fin = 1'b1;
            end else if (pause) begin
               push($sformatf("%s_p%0d", name, cyc),
                    row(cnt_of(t, up, k), 1'b0, k / n, 1'b1, 1'b0, 1'b0));
            end else begin
               k++;
               if ((r != 0) && (k == r * n)) begin
                  push($sformatf("%s_done", name), row(cnt_of(t, up, k), 1'b1, r, 1'b0, 1'b1, 1'b0));
                  dn = 1'b1;
               end else begin
                  push($sformatf("%s_c%0d", name, cyc),
                       row(cnt_of(t, up, k), (k % n) == 0, k / n, 1'b1, 1'b0, 1'b0));
               end
            end
         end
      end
      @(negedge clk);
      pause     = 1'b0;
      abort     = 1'b0;
      cmd_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_term  = 4'd0;
      cmd_reps  = 8'd0;
      cmd_up    = 1'b1;
      pause     = 1'b0;
      abort     = 1'b0;
      repeat (2) @(negedge clk);
      chk_val("reset_state", w_obs, row(0, 1'b0, 0, 1'b0, 1'b0, 1'b1));
      rst = 1'b1;

      // Reset mid-run: outputs must clear before any further clock edge.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_term  = 4'd7;
      cmd_reps  = 8'd2;
      cmd_up    = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_val("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk_val("async_reset", w_obs, row(0, 1'b0, 0, 1'b0, 1'b0, 1'b1));
      @(negedge clk);
      chk_val("reset_held", w_obs, row(0, 1'b0, 0, 1'b0, 1'b0, 1'b1));
      rst = 1'b1;

      run_cmd("mod4up",  3, 2, 1'b1, -1, 0, -1, -1);
      run_cmd("downfr",  5, 0, 1'b0, -1, 0, 1541, -1);
      run_cmd("pause",   3, 1, 1'b1,  3, 3, -1, 2);
      run_cmd("abort",   3, 1, 1'b1, -1, 0, 4, -1);
      run_cmd("term0",   0, 3, 1'b1, -1, 0, -1, -1);
      run_cmd("down2",   2, 2, 1'b0,  2, 1, -1, -1);

      repeat (2) @(negedge clk);
      chk_val("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
